frame_buffer_scheduler: RTL

FRAME_BUFFER_SCHEDULER -- requirements
Module: frame_buffer_scheduler

---
 rtl/frame_buffer_scheduler.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// frame_buffer_scheduler
//
// Triple-buffer slot manager between one frame writer and one frame reader.
// Three slots cycle through FREE -> WRITING -> READY -> READING -> FREE.
// The writer always gets a slot immediately. The reader only gets the single
// most recent completed frame. A completed frame that is replaced before the
// reader claims it is dropped and counted.
//
// Ports
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   pixels_per_frame : slot size in address units, sampled at each grant
//   wr_req           : writer slot request, held until wr_grant
//   wr_grant         : one-cycle pulse, writer slot granted
//   wr_slot          : slot index granted to the writer (held until next grant)
//   wr_base_addr     : wr_slot * pixels_per_frame (held until next grant)
//   wr_done          : one-cycle pulse, writer finished its frame
//   rd_req           : reader frame request, held until rd_grant
//   rd_grant         : one-cycle pulse, reader frame granted
//   rd_slot          : slot index granted to the reader (held until next grant)
//   rd_base_addr     : rd_slot * pixels_per_frame (held until next grant)
//   rd_done          : one-cycle pulse, reader finished with its slot
//   frame_available  : registered flag, a READY slot exists
//   frames_dropped   : saturating count of completed frames discarded unread
// ---------------------------------------------------------------------------
module frame_buffer_scheduler #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pixels_per_frame,
    input  logic                  wr_req,
    output logic                  wr_grant,
    output logic [1:0]            wr_slot,
    output logic [ADDR_WIDTH-1:0] wr_base_addr,
    input  logic                  wr_done,
    input  logic                  rd_req,
    output logic                  rd_grant,
    output logic [1:0]            rd_slot,
    output logic [ADDR_WIDTH-1:0] rd_base_addr,
    input  logic                  rd_done,
    output logic                  frame_available,
    output logic [15:0]           frames_dropped
);

    localparam int NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WRITING = 2'd1,
        SLOT_READY   = 2'd2,
        SLOT_READING = 2'd3
    } slot_state_t;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_ACTIVE = 1'b1
    } r_state_t;

    // Slot base address: index * size. The index is at most 2, so the
    // product is built from shifts and then zero-extended/truncated.
    function automatic logic [ADDR_WIDTH-1:0] slot_base_f(
        input logic [1:0]  slot,
        input logic [31:0] ppf
    );
        logic [33:0]            prod;
        logic [ADDR_WIDTH+33:0] wide;
        case (slot)
            2'd1:    prod = {2'b00, ppf};
            2'd2:    prod = {1'b0, ppf, 1'b0};
            default: prod = 34'd0;
        endcase
        wide = {{ADDR_WIDTH{1'b0}}, prod};
        return wide[ADDR_WIDTH-1:0];
    endfunction

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc_f(input logic [15:0] val);
        return (val == 16'hFFFF) ? 16'hFFFF : (val + 16'd1);
    endfunction

    // Registered state
    slot_state_t           slot_r [NUM_SLOTS];
    w_state_t              w_state_r;
    r_state_t              r_state_r;
    logic                  wr_grant_r;
    logic [1:0]            wr_slot_r;
    logic [ADDR_WIDTH-1:0] wr_base_addr_r;
    logic                  rd_grant_r;
    logic [1:0]            rd_slot_r;
    logic [ADDR_WIDTH-1:0] rd_base_addr_r;
    logic                  frame_available_r;
    logic [15:0]           frames_dropped_r;

    // Combinational decisions
    slot_state_t slot_nxt_s [NUM_SLOTS];
    logic        free_found_s;
    logic [1:0]  free_idx_s;
    logic        ready_found_s;
    logic [1:0]  ready_idx_s;
    logic        wr_start_s;
    logic        wr_commit_s;
    logic        rd_claim_s;
    logic        rd_release_s;
    logic        drop_s;
    logic        any_ready_nxt_s;

    // Locate the lowest-index FREE slot and the (single) READY slot.
    always_comb begin
        free_found_s  = 1'b0;
        free_idx_s    = 2'd0;
        ready_found_s = 1'b0;
        ready_idx_s   = 2'd0;
        // Descending scan so the lowest matching index is the last write.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            free_found_s  = free_found_s  | (slot_r[i] == SLOT_FREE);
            free_idx_s    = (slot_r[i] == SLOT_FREE)  ? i[1:0] : free_idx_s;
            ready_found_s = ready_found_s | (slot_r[i] == SLOT_READY);
            ready_idx_s   = (slot_r[i] == SLOT_READY) ? i[1:0] : ready_idx_s;
        end
    end

    // Channel events for this cycle, decided from registered state only.
    always_comb begin
        wr_start_s   = (w_state_r == W_IDLE)   && wr_req && free_found_s;
        wr_commit_s  = (w_state_r == W_ACTIVE) && wr_done;
        rd_claim_s   = (r_state_r == R_IDLE)   && rd_req && ready_found_s;
        rd_release_s = (r_state_r == R_ACTIVE) && rd_done;
        // A READY frame being claimed this cycle survives a new commit.
        drop_s       = wr_commit_s && ready_found_s && !rd_claim_s;
    end

    // Next slot states. Each event touches a slot in a distinct state, so
    // at most one branch can match any given slot.
    always_comb begin
        any_ready_nxt_s = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_release_s && (rd_slot_r == i[1:0]) && (slot_r[i] == SLOT_READING)) begin
                slot_nxt_s[i] = SLOT_FREE;
            end else if (rd_claim_s && (ready_idx_s == i[1:0])) begin
                slot_nxt_s[i] = SLOT_READING;
            end else if (drop_s && (ready_idx_s == i[1:0])) begin
                slot_nxt_s[i] = SLOT_FREE;
            end else if (wr_commit_s && (wr_slot_r == i[1:0]) && (slot_r[i] == SLOT_WRITING)) begin
                slot_nxt_s[i] = SLOT_READY;
            end else if (wr_start_s && (free_idx_s == i[1:0])) begin
                slot_nxt_s[i] = SLOT_WRITING;
            end else begin
                slot_nxt_s[i] = slot_r[i];
            end
            any_ready_nxt_s = any_ready_nxt_s | (slot_nxt_s[i] == SLOT_READY);
        end
    end

    // Slot table, both channel FSMs and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_r[i] <= SLOT_FREE;
            end
            w_state_r         <= W_IDLE;
            r_state_r         <= R_IDLE;
            wr_grant_r        <= 1'b0;
            wr_slot_r         <= 2'd0;
            wr_base_addr_r    <= {ADDR_WIDTH{1'b0}};
            rd_grant_r        <= 1'b0;
            rd_slot_r         <= 2'd0;
            rd_base_addr_r    <= {ADDR_WIDTH{1'b0}};
            frame_available_r <= 1'b0;
            frames_dropped_r  <= 16'd0;
        end else begin
            slot_r            <= slot_nxt_s;
            frame_available_r <= any_ready_nxt_s;
            wr_grant_r        <= wr_start_s;
            rd_grant_r        <= rd_claim_s;

            case (w_state_r)
                W_IDLE: begin
                    if (wr_start_s) begin
                        wr_slot_r      <= free_idx_s;
                        wr_base_addr_r <= slot_base_f(free_idx_s, pixels_per_frame);
                        w_state_r      <= W_ACTIVE;
                    end
                end
                W_ACTIVE: begin
                    if (wr_commit_s) begin
                        w_state_r <= W_IDLE;
                    end
                end
                default: w_state_r <= W_IDLE;
            endcase

            case (r_state_r)
                R_IDLE: begin
                    if (rd_claim_s) begin
                        rd_slot_r      <= ready_idx_s;
                        rd_base_addr_r <= slot_base_f(ready_idx_s, pixels_per_frame);
                        r_state_r      <= R_ACTIVE;
                    end
                end
                R_ACTIVE: begin
                    if (rd_release_s) begin
                        r_state_r <= R_IDLE;
                    end
                end
                default: r_state_r <= R_IDLE;
            endcase

            if (drop_s) begin
                frames_dropped_r <= sat_inc_f(frames_dropped_r);
            end
        end
    end

    assign wr_grant        = wr_grant_r;
    assign wr_slot         = wr_slot_r;
    assign wr_base_addr    = wr_base_addr_r;
    assign rd_grant        = rd_grant_r;
    assign rd_slot         = rd_slot_r;
    assign rd_base_addr    = rd_base_addr_r;
    assign frame_available = frame_available_r;
    assign frames_dropped  = frames_dropped_r;

endmodule
